// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive/transmit blocks: FSM state encoding,
// special characters and the bit-period computation.
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_START      = 3'd2,
        ST_DATA       = 3'd3,
        ST_STOP       = 3'd4,
        ST_STORE      = 3'd5,
        ST_DONE       = 3'd6
    } state_e;

    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    function automatic int calc_bit_ticks(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, bit timer and START/DATA/STOP FSM.
// Emits one-cycle byte_valid / frame_error strobes; disarming returns it to idle.
module uart_rx_byte
    import serial_pkg::*;
#(
    parameter int BIT_TICKS  = 5208,
    parameter int HALF_TICKS = 2604
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    input  logic       arm,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int TW = $clog2(BIT_TICKS + 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF_TICKS - 1);

    logic [1:0]    sync_q;
    state_e        ph_q, ph_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          brk_q, brk_d;
    logic          rx_s;

    assign rx_s        = sync_q[1];
    assign byte_out    = data_q;
    assign byte_valid  = valid_q;
    assign frame_error = ferr_q;

    // Bit-level decode; brk_q holds STOP after a framing error until the line idles high.
    always_comb begin
        ph_d    = ph_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        brk_d   = brk_q;
        if (!arm) begin
            ph_d    = ST_IDLE;
            timer_d = {TW{1'b0}};
            bit_d   = 3'd0;
            brk_d   = 1'b0;
        end else begin
            case (ph_q)
                ST_IDLE: begin
                    ph_d    = ST_WAIT_START;
                    timer_d = {TW{1'b0}};
                end
                ST_WAIT_START: begin
                    if (!rx_s) begin
                        ph_d    = ST_START;
                        timer_d = {TW{1'b0}};
                    end else begin
                        ph_d = ST_WAIT_START;
                    end
                end
                ST_START: begin
                    if (timer_q == HALF_LAST) begin
                        timer_d = {TW{1'b0}};
                        bit_d   = 3'd0;
                        ph_d    = rx_s ? ST_WAIT_START : ST_DATA;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (timer_q == BIT_LAST) begin
                        timer_d = {TW{1'b0}};
                        shift_d = {rx_s, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            ph_d = ST_STOP;
                        end else begin
                            ph_d = ST_DATA;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (brk_q) begin
                        if (rx_s) begin
                            brk_d = 1'b0;
                            ph_d  = ST_WAIT_START;
                        end else begin
                            ph_d = ST_STOP;
                        end
                    end else if (timer_q == BIT_LAST) begin
                        timer_d = {TW{1'b0}};
                        if (rx_s) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            ph_d    = ST_WAIT_START;
                        end else begin
                            ferr_d = 1'b1;
                            brk_d  = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: begin
                    ph_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers; the synchronizer resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            ph_q    <= ST_IDLE;
            timer_q <= {TW{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_in};
            ph_q    <= ph_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
        end
    end

endmodule

// File: rtl/string_rx_serial.sv
// Receives NUM_CHARS UART characters into string_out (first char in the MSBs).
// Optional macro STRING_RX_TERMINATOR_EN: a received CR ends the string, space-padded.
module string_rx_serial
    import serial_pkg::*;
#(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200,
    parameter int NUM_CHARS     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_in,
    input  logic                   enable,
    output logic [8*NUM_CHARS-1:0] string_out,
    output logic                   done,
    output logic                   rx_error
);

    localparam int BIT_TICKS  = calc_bit_ticks(CLK_FREQUENCY, BAUD_RATE);
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int IW         = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_CHARS - 1);

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [8*NUM_CHARS-1:0] str_q, str_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   arm_s;
    logic                   term_s;
    logic                   full_s;
    logic [7:0]             rx_byte_s;
    logic                   rx_valid_s;
    logic                   rx_ferr_s;

    assign string_out = str_q;
    assign done       = done_q;
    assign rx_error   = err_q;
    // Receiver stays armed through STORE so a start edge right after a stop bit is kept.
    assign arm_s      = enable && ((state_q == ST_WAIT_START) || (state_q == ST_STORE));

    uart_rx_byte #(
        .BIT_TICKS  (BIT_TICKS),
        .HALF_TICKS (HALF_TICKS)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .rx_in       (rx_in),
        .arm         (arm_s),
        .byte_out    (rx_byte_s),
        .byte_valid  (rx_valid_s),
        .frame_error (rx_ferr_s)
    );

`ifdef STRING_RX_TERMINATOR_EN
    assign term_s = (rx_byte_s == CHAR_CR);
`else
    assign term_s = 1'b0;
`endif

    // String assembly and enable handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        str_d   = str_q;
        err_d   = err_q;
        full_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WAIT_START;
                    idx_d   = {IW{1'b0}};
                    str_d   = {(8*NUM_CHARS){1'b0}};
                    err_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_START: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    if (rx_ferr_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    state_d = rx_valid_s ? ST_STORE : ST_WAIT_START;
                end
            end
            ST_STORE: begin
                if (term_s) begin
                    for (int i = 0; i < NUM_CHARS; i++) begin
                        if (i >= int'(idx_q)) begin
                            str_d[8*(NUM_CHARS-1-i) +: 8] = CHAR_SPACE;
                        end else begin
                            str_d[8*(NUM_CHARS-1-i) +: 8] = str_q[8*(NUM_CHARS-1-i) +: 8];
                        end
                    end
                    full_s = 1'b1;
                end else begin
                    for (int i = 0; i < NUM_CHARS; i++) begin
                        if (IW'(i) == idx_q) begin
                            str_d[8*(NUM_CHARS-1-i) +: 8] = rx_byte_s;
                        end else begin
                            str_d[8*(NUM_CHARS-1-i) +: 8] = str_q[8*(NUM_CHARS-1-i) +: 8];
                        end
                    end
                    idx_d  = idx_q + IW'(1);
                    full_s = (idx_q == IDX_LAST);
                end
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (full_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT_START;
                end
            end
            ST_DONE: begin
                state_d = enable ? ST_DONE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        done_d = (state_d == ST_DONE);
    end

    // Handshake registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= {IW{1'b0}};
            str_q   <= {(8*NUM_CHARS){1'b0}};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            str_q   <= str_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule
